// File: rtl/data_sram_responder.sv
// data_sram_responder
//   Slave side of the SRAM-like data memory port. Requests are accepted with
//   addr_ok, up to DEPTH of them are held in an in-order queue, and each one is
//   answered with a single-cycle data_ok pulse exactly LATENCY cycles after it
//   was accepted. Backed by a word-organised memory of 2^ADDR_BITS words.
//
// Ports
//   clk               clock
//   resetn            synchronous active-low reset
//   data_sram_req     request valid
//   data_sram_wr      1 = write, 0 = read
//   data_sram_size    access size (ignored; the full word is always returned)
//   data_sram_wstrb   byte enables for writes
//   data_sram_addr    byte address; word index = addr[ADDR_BITS+1:2]
//   data_sram_wdata   write data, already lane-replicated
//   data_sram_addr_ok request accepted this cycle when high with req
//   data_sram_data_ok registered one-cycle response pulse
//   data_sram_rdata   registered read data (0 for writes), valid with data_ok
module data_sram_responder #(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 2,
  parameter int DEPTH     = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  localparam int WORDS = 1 << ADDR_BITS;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int AGE_W = 4;

  logic [31:0]          mem [0:WORDS-1];
  logic [ADDR_BITS-1:0] word_idx;
  logic                 accept;
  logic [31:0]          rd_word_q;
  logic                 data_ok_q;
  logic                 unused_inputs;

  assign word_idx          = data_sram_addr[ADDR_BITS+1:2];
  assign accept            = data_sram_req & data_sram_addr_ok;
  assign data_sram_data_ok = data_ok_q;
  // Size and the address bits outside the word index never affect behaviour.
  assign unused_inputs     = ^{data_sram_size, data_sram_addr};

  // Byte-lane write port; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (accept && data_sram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (data_sram_wstrb[b]) begin
          mem[word_idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
        end
      end
    end
  end

  // Registered read port. Only one accept happens per cycle, so a read never
  // races a write to the same word; the previous cycle's write is already in.
  // Writes load zero so the value can be forwarded as the response directly.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_word_q <= '0;
    end else if (accept) begin
      rd_word_q <= data_sram_wr ? 32'h0 : mem[word_idx];
    end
  end

  if (LATENCY == 1) begin : g_direct
    // Every request is answered the cycle right after acceptance, so nothing
    // is ever queued and the port can always accept.
    assign data_sram_addr_ok = 1'b1;
    assign data_sram_rdata   = rd_word_q;

    always_ff @(posedge clk) begin
      if (!resetn) begin
        data_ok_q <= 1'b0;
      end else begin
        data_ok_q <= accept;
      end
    end
  end else begin : g_queue
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wptr_q, rptr_q;
    logic [PTR_W-1:0] fill_ptr_q;
    logic             fill_pend_q;
    logic             vld_q      [DEPTH];
    logic             ent_wr_q   [DEPTH];
    logic [AGE_W-1:0] age_q      [DEPTH];
    logic [31:0]      ent_rdata_q[DEPTH];
    logic [31:0]      rdata_q;
    logic [31:0]      head_word;
    logic             retire;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign data_sram_addr_ok = (count_q < CNT_W'(DEPTH));
    assign data_sram_rdata   = rdata_q;

    // The accept cycle counts as age 0, so an entry first becomes visible with
    // age 1 and pops at the end of the cycle where its age reaches LATENCY-1.
    assign retire = vld_q[rptr_q] && (age_q[rptr_q] == AGE_W'(LATENCY - 1));

    // The read word lands in rd_word_q one cycle before it is copied into its
    // entry; if the head retires in that gap, take it from rd_word_q.
    assign head_word = (fill_pend_q && (fill_ptr_q == rptr_q)) ? rd_word_q
                                                               : ent_rdata_q[rptr_q];

    always_comb begin
      count_d = count_q + CNT_W'(accept) - CNT_W'(retire);
    end

    always_ff @(posedge clk) begin
      if (!resetn) begin
        count_q     <= '0;
        wptr_q      <= '0;
        rptr_q      <= '0;
        fill_pend_q <= 1'b0;
        fill_ptr_q  <= '0;
        data_ok_q   <= 1'b0;
        rdata_q     <= '0;
      end else begin
        count_q     <= count_d;
        fill_pend_q <= accept;
        fill_ptr_q  <= wptr_q;
        data_ok_q   <= retire;
        if (accept) wptr_q <= next_ptr(wptr_q);
        if (retire) rptr_q <= next_ptr(rptr_q);
        if (retire && !ent_wr_q[rptr_q]) begin
          rdata_q <= head_word;
        end else begin
          rdata_q <= '0;
        end
      end
    end

    // Per-slot bookkeeping. A slot can't be written and popped in the same
    // cycle: that needs wptr == rptr, which only happens when empty or full.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      always_ff @(posedge clk) begin
        if (!resetn) begin
          vld_q[gi]    <= 1'b0;
          ent_wr_q[gi] <= 1'b0;
          age_q[gi]    <= '0;
        end else if (accept && (wptr_q == PTR_W'(gi))) begin
          vld_q[gi]    <= 1'b1;
          ent_wr_q[gi] <= data_sram_wr;
          age_q[gi]    <= AGE_W'(1);
        end else if (retire && (rptr_q == PTR_W'(gi))) begin
          vld_q[gi]    <= 1'b0;
          age_q[gi]    <= '0;
        end else if (vld_q[gi]) begin
          age_q[gi]    <= age_q[gi] + AGE_W'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (fill_pend_q && (fill_ptr_q == PTR_W'(gi))) begin
          ent_rdata_q[gi] <= rd_word_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
module tb_data_sram_responder;
  localparam int AB  = 10;
  localparam int LAT = 3;
  localparam int DEP = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req, wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  data_sram_responder #(.ADDR_BITS(AB), .LATENCY(LAT), .DEPTH(DEP)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .data_sram_req    (req),
    .data_sram_wr     (wr),
    .data_sram_size   (size),
    .data_sram_wstrb  (wstrb),
    .data_sram_addr   (addr),
    .data_sram_wdata  (wdata),
    .data_sram_addr_ok(addr_ok),
    .data_sram_data_ok(data_ok),
    .data_sram_rdata  (rdata)
  );

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];            // expected responses, in order
  int          inflight_due[$];  // model of accepted-but-unretired requests
  logic [31:0] mem_model [int];  // word index -> contents
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  bit          mon_en = 0;
  bit          mon_exp;
  exp_t        mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
  endfunction

  // Monitor: every cycle data_ok must be high exactly when the oldest
  // expected response is due, and then carry the expected word.
  always @(negedge clk) begin
    if (mon_en) begin
      mon_exp = (sb.size() > 0) && (sb[0].due == cyc);
      chk("data_ok", {31'b0, data_ok}, {31'b0, mon_exp});
      if (mon_exp) begin
        mon_e = sb.pop_front();
        if (data_ok) begin
          chk("rdata", rdata, mon_e.data);
          $display("resp cycle %0d rdata %h expected %h", cyc, rdata, mon_e.data);
        end
      end
    end
  end

  // Model occupancy: a request due in cycle d stops counting in cycle d.
  function automatic void prune();
    while (inflight_due.size() > 0 && inflight_due[0] <= cyc) void'(inflight_due.pop_front());
  endfunction

  task automatic scramble();
    wr    = 1'($urandom);
    size  = 2'($urandom);
    wstrb = 4'($urandom);
    addr  = $urandom;
    wdata = $urandom;
  endtask

  task automatic idle(int n);
    repeat (n) begin
      req = 1'b0;
      scramble();
      prune();
      chk("addr_ok_idle", {31'b0, addr_ok}, {31'b0, (inflight_due.size() < DEP)});
      @(posedge clk);
      #1;
    end
  endtask

  // Present a request and hold it until the model says it is accepted.
  task automatic issue(bit w, logic [31:0] a, logic [31:0] d, logic [3:0] s);
    int   idx, c;
    bit   acc, exp_ok;
    exp_t e;
    logic [31:0] old;
    idx = int'((a >> 2) & ((32'd1 << AB) - 1));
    req = 1'b1; wr = w; addr = a; wdata = d; wstrb = s;
    size = 2'($urandom_range(0, 2));
    acc = 0;
    while (!acc) begin
      prune();
      exp_ok = (inflight_due.size() < DEP);
      chk("addr_ok", {31'b0, addr_ok}, {31'b0, exp_ok});
      c = cyc;
      @(posedge clk);
      if (exp_ok) begin
        acc   = 1;
        e.due = c + LAT;
        if (w) begin
          old = mem_model.exists(idx) ? mem_model[idx] : 32'h0;
          for (int b = 0; b < 4; b++) if (s[b]) old[8*b +: 8] = d[8*b +: 8];
          mem_model[idx] = old;
          e.data = 32'h0;
        end else begin
          e.data = mem_model[idx];
        end
        sb.push_back(e);
        inflight_due.push_back(e.due);
        $display("accept cycle %0d %s addr %h wdata %h wstrb %b due %0d",
                 c, w ? "WR" : "RD", a, d, s, e.due);
      end
      #1;
    end
    req = 1'b0;
  endtask

  // Responses not yet delivered at the reset edge are discarded.
  task automatic do_reset(int n);
    resetn = 1'b0;
    req    = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    sb.delete();
    inflight_due.delete();
    resetn = 1'b1;
    chk("reset_addr_ok", {31'b0, addr_ok}, 32'd1);
    chk("reset_data_ok", {31'b0, data_ok}, 32'd0);
    chk("reset_rdata", rdata, 32'h0);
  endtask

  int          word_set[16];
  int          k;
  logic [31:0] a;

  initial begin
    resetn = 1'b0;
    req    = 1'b0;
    scramble();
    for (int i = 0; i < 16; i++) word_set[i] = (i * 67 + 5) % (1 << AB);
    @(posedge clk);
    #1;

    do_reset(2);
    mon_en = 1;
    idle(10);

    // Full write then read of the same word, back to back.
    issue(1, 32'h0000_1000, 32'hDEAD_BEEF, 4'b1111);
    issue(0, 32'h0000_1000, 32'h0, 4'b0000);
    // Single-byte update.
    issue(1, 32'h0000_1000, 32'h0000_AB00, 4'b0010);
    issue(0, 32'h0000_1000, 32'h0, 4'b0000);
    // Write with no byte enables still answers and changes nothing.
    issue(1, 32'h0000_1000, 32'hFFFF_FFFF, 4'b0000);
    issue(0, 32'h0000_1000, 32'h0, 4'b0000);
    // Aliasing through the upper address bits.
    issue(1, 32'h0000_1000, 32'h1234_5678, 4'b1111);
    issue(0, 32'h8000_1000, 32'h0, 4'b0000);
    idle(LAT + 1);

    // Three held requests against a full queue.
    issue(0, 32'h0000_1000, 32'h0, 4'b0000);
    issue(1, 32'h0000_1004, 32'hCAFE_F00D, 4'b1111);
    issue(0, 32'h0000_1004, 32'h0, 4'b0000);
    idle(LAT + 1);

    // Reset with two reads in flight.
    issue(0, 32'h0000_1000, 32'h0, 4'b0000);
    issue(0, 32'h0000_1004, 32'h0, 4'b0000);
    do_reset(1);
    idle(8);

    // Randomized traffic over a small, pre-initialised set of words.
    for (int i = 0; i < 16; i++) issue(1, 32'(word_set[i]) << 2, $urandom, 4'b1111);
    for (int t = 0; t < 200; t++) begin
      k = $urandom_range(0, 15);
      a = ($urandom & 32'hFFFF_F003) | (32'(word_set[k]) << 2);
      issue(1'($urandom), a, $urandom, 4'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    idle(LAT + 3);
    chk("drain_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
